// File: rtl/tof_pkg.sv
// Shared word-type codes, invalid-result marker and FSM encoding for the TOF result reader.
package tof_pkg;

    localparam logic [1:0]  TYPE_HDR = 2'b00;
    localparam logic [1:0]  TYPE_HIT = 2'b01;
    localparam logic [1:0]  TYPE_INV = 2'b10;
    localparam logic [1:0]  TYPE_TRL = 2'b11;

    localparam logic [14:0] INVALID_CODE = 15'h7FFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        COLLECT = 2'd2,
        TRAILER = 2'd3
    } state_t;

    // Stream word as stored in the FIFO: {last, type, payload}
    function automatic logic [18:0] mk_word(input logic last, input logic [1:0] typ,
                                            input logic [15:0] payload);
        return {last, typ, payload};
    endfunction

endpackage

// File: rtl/tof_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_dat/rd_en act as a valid/ready read port.
// Write accepted when not full, or when full with a read in the same cycle; reads stall on empty.
module tof_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Output forced to zero while empty so nothing undefined leaks onto the link
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/tof_result_reader.sv
// Frames TDC stop results into header/hit/trailer words and streams them through a FIFO.
// Strobe at N is written at N+1, visible at N+2; header/hit dropped when full, trailer stalls.
module tof_result_reader #(
    parameter int          DEPTH        = 8,
    parameter int          MAX_HITS     = 4,
    parameter int          TIMEOUT      = 1023,
    parameter logic [14:0] INVALID_CODE = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tri_en,
    input  logic        tof_valid,
    input  logic [14:0] tof_data,
    input  logic [1:0]  tof_num_cnt,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [17:0] m_data,
    output logic        m_last,
    output logic        busy,
    output logic        overflow
);

    import tof_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_n;
    logic          tri_q, vld_q;
    logic [14:0]   dat_q;
    logic [1:0]    num_q;
    logic [7:0]    frame_id, frame_n;
    logic [2:0]    hit_cnt, hit_cnt_n, hit_inc;
    logic [2:0]    inv_cnt, inv_cnt_n, inv_inc;
    logic [TW-1:0] timer, timer_n;
    logic          tflag, tflag_n;
    logic          restart, restart_n;
    logic          pend_hdr, pend_n;
    logic          ovf_set;
    logic          want_wr, trl_wr;
    logic [18:0]   wr_word, hdr_word, hit_word, trl_word;
    logic          fifo_wr, fifo_full, fifo_empty, fifo_space;
    logic [18:0]   rd_word;

    // Inputs are aligned through one register stage so that a coincident tri_en/tof_valid
    // is seen in the same FSM cycle and the hit lands before the trailer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tri_q <= 1'b0;
            vld_q <= 1'b0;
            dat_q <= '0;
            num_q <= '0;
        end else begin
            tri_q <= tri_en;
            vld_q <= tof_valid;
            dat_q <= tof_data;
            num_q <= tof_num_cnt;
        end
    end

    assign hit_inc  = (hit_cnt >= 3'(MAX_HITS)) ? hit_cnt : hit_cnt + 3'd1;
    assign inv_inc  = (inv_cnt >= 3'(MAX_HITS)) ? inv_cnt : inv_cnt + 3'd1;
    assign hdr_word = mk_word(1'b0, TYPE_HDR, {frame_id, 8'h00});
    assign hit_word = (dat_q == INVALID_CODE) ? mk_word(1'b0, TYPE_INV, {num_q, 14'h0})
                                              : mk_word(1'b0, TYPE_HIT, {num_q[0], dat_q});
    assign trl_word = mk_word(1'b1, TYPE_TRL, {hit_cnt, inv_cnt, tflag, overflow, 8'h00});

    // When full, m_valid is high, so m_ready guarantees a read frees a slot this cycle
    assign fifo_space = !fifo_full || m_ready;

    always_comb begin
        state_n   = state;
        frame_n   = frame_id;
        hit_cnt_n = hit_cnt;
        inv_cnt_n = inv_cnt;
        timer_n   = timer;
        tflag_n   = tflag;
        restart_n = restart;
        pend_n    = pend_hdr;
        ovf_set   = 1'b0;
        want_wr   = 1'b0;
        trl_wr    = 1'b0;
        wr_word   = hdr_word;
        case (state)
            IDLE: begin
                if (vld_q) ovf_set = 1'b1;
                if (tri_q) begin
                    want_wr = 1'b1;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (pend_hdr || tri_q) want_wr = 1'b1;
                pend_n = 1'b0;
                if (!tri_q && vld_q) begin
                    state_n   = COLLECT;
                    hit_cnt_n = '0;
                    inv_cnt_n = '0;
                    timer_n   = '0;
                    tflag_n   = 1'b0;
                    restart_n = 1'b0;
                end
            end
            COLLECT: begin
                if (vld_q) begin
                    want_wr   = 1'b1;
                    wr_word   = hit_word;
                    hit_cnt_n = hit_inc;
                    if (dat_q == INVALID_CODE) inv_cnt_n = inv_inc;
                    timer_n   = '0;
                    if (hit_inc >= 3'(MAX_HITS) || tri_q) begin
                        state_n   = TRAILER;
                        restart_n = tri_q;
                    end
                end else if (tri_q) begin
                    state_n   = TRAILER;
                    restart_n = 1'b1;
                end else if (timer >= TW'(TIMEOUT)) begin
                    state_n = TRAILER;
                    tflag_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            TRAILER: begin
                if (vld_q) ovf_set = 1'b1;
                if (tri_q) restart_n = 1'b1;
                wr_word = trl_word;
                if (fifo_space) begin
                    trl_wr    = 1'b1;
                    frame_n   = frame_id + 8'd1;
                    restart_n = 1'b0;
                    pend_n    = restart || tri_q;
                    state_n   = (restart || tri_q) ? ARMED : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (want_wr && !fifo_space) ovf_set = 1'b1;
    end

    assign fifo_wr = (want_wr && fifo_space) || trl_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            frame_id <= '0;
            hit_cnt  <= '0;
            inv_cnt  <= '0;
            timer    <= '0;
            tflag    <= 1'b0;
            restart  <= 1'b0;
            pend_hdr <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            frame_id <= frame_n;
            hit_cnt  <= hit_cnt_n;
            inv_cnt  <= inv_cnt_n;
            timer    <= timer_n;
            tflag    <= tflag_n;
            restart  <= restart_n;
            pend_hdr <= pend_n;
            if (ovf_set) overflow <= 1'b1;
        end
    end

    tof_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (19)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (fifo_wr),
        .wr_dat (wr_word),
        .full   (fifo_full),
        .rd_en  (m_ready),
        .rd_dat (rd_word),
        .empty  (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = rd_word[17:0];
    assign m_last  = rd_word[18];
    assign busy    = (state != IDLE);

endmodule
